// File: rtl/trunk_unit_if.sv
// Load-data bus between the memory stage and the truncation/extension unit.
interface trunk_unit_if;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 12;

   logic [OP_W-1:0]   opcode;
   logic [DATA_W-1:0] entrada;
   logic [ADDR_W-1:0] direccion;
   logic [DATA_W-1:0] salida;

   // Memory stage drives the load request and consumes the result.
   modport master (
      output opcode,
      output entrada,
      output direccion,
      input  salida
   );

   // Truncation unit consumes the request and drives the result.
   modport slave (
      input  opcode,
      input  entrada,
      input  direccion,
      output salida
   );
endinterface

// File: rtl/trunk_unit.sv
// Load-data truncation and extension: picks the byte/halfword/word a load
// asks for out of the memory word and extends it to 32 bits, registered.
module trunk_unit (
   input  logic         clk,
   input  logic         reset,
   trunk_unit_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;

   logic [BYTE_W-1:0] byte_c;
   logic [HALF_W-1:0] half_c;
   logic [DATA_W-1:0] result_c;
   logic              unused_addr_c;

   // Only the byte offset within the word matters.
   assign unused_addr_c = ^bus.direccion[11:2];

   // Little-endian byte lane select.
   always_comb begin
      byte_c = bus.entrada[7:0];
      unique case (bus.direccion[1:0])
         2'd0: byte_c = bus.entrada[7:0];
         2'd1: byte_c = bus.entrada[15:8];
         2'd2: byte_c = bus.entrada[23:16];
         2'd3: byte_c = bus.entrada[31:24];
         default: byte_c = bus.entrada[7:0];
      endcase
   end

   // Aligned halfword containing the address; bit 0 is ignored.
   always_comb begin
      half_c = bus.entrada[15:0];
      if (bus.direccion[1]) begin
         half_c = bus.entrada[31:16];
      end
   end

   // Extension by load type; LW, LWL, LWR and unused codes pass the word.
   always_comb begin
      result_c = bus.entrada;
      case (bus.opcode)
         OP_LB:   result_c = {{(DATA_W-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
         OP_LH:   result_c = {{(DATA_W-HALF_W){half_c[HALF_W-1]}}, half_c};
         OP_LBU:  result_c = {{(DATA_W-BYTE_W){1'b0}}, byte_c};
         OP_LHU:  result_c = {{(DATA_W-HALF_W){1'b0}}, half_c};
         default: result_c = bus.entrada;
      endcase
   end

   // Output register into write-back; reset dominates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.salida <= DATA_W'(0);
      end else begin
         bus.salida <= result_c;
      end
   end
endmodule

// File: tb/tb_trunk_unit.sv
// Directed table-driven bench for trunk_unit.
module tb_trunk_unit;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   trunk_unit_if bus ();

   trunk_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  opcode;
      logic [31:0] entrada;
      logic [11:0] direccion;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic add(input string name, input logic [2:0] op,
                      input logic [31:0] d, input logic [11:0] a,
                      input logic [31:0] e);
      vec_t v;
      v.name = name; v.opcode = op; v.entrada = d; v.direccion = a;
      v.expected = e;
      vecs.push_back(v);
   endtask

   // Drive on the falling edge, sample 1 time unit after the next rising edge.
   task automatic apply(input logic [2:0] op, input logic [31:0] d,
                        input logic [11:0] a);
      @(negedge clk);
      bus.opcode    = op;
      bus.entrada   = d;
      bus.direccion = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      add("ones_op0",  3'd0, 32'hFFFFFFFF, 12'h000, 32'hFFFFFFFF);
      add("ones_op1",  3'd1, 32'hFFFFFFFF, 12'h000, 32'hFFFFFFFF);
      add("ones_op2",  3'd2, 32'hFFFFFFFF, 12'h000, 32'hFFFFFFFF);
      add("ones_op3",  3'd3, 32'hFFFFFFFF, 12'h000, 32'hFFFFFFFF);
      add("lb_a0",     3'd0, 32'h807F01FE, 12'h000, 32'hFFFFFFFE);
      add("lb_a1",     3'd0, 32'h807F01FE, 12'h001, 32'h00000001);
      add("lb_a2",     3'd0, 32'h807F01FE, 12'h002, 32'h0000007F);
      add("lb_a3",     3'd0, 32'h807F01FE, 12'h003, 32'hFFFFFF80);
      add("lbu_a0",    3'd4, 32'h807F01FE, 12'h000, 32'h000000FE);
      add("lbu_a1",    3'd4, 32'h807F01FE, 12'h001, 32'h00000001);
      add("lbu_a2",    3'd4, 32'h807F01FE, 12'h002, 32'h0000007F);
      add("lbu_a3",    3'd4, 32'h807F01FE, 12'h003, 32'h00000080);
      add("lh_a0",     3'd1, 32'h80017FFF, 12'h000, 32'h00007FFF);
      add("lh_a2",     3'd1, 32'h80017FFF, 12'h002, 32'hFFFF8001);
      add("lhu_a2",    3'd5, 32'h80017FFF, 12'h002, 32'h00008001);
      add("lh_a3",     3'd1, 32'h80017FFF, 12'h003, 32'hFFFF8001);
      add("lhu_a0",    3'd5, 32'h80017FFF, 12'h001, 32'h00007FFF);
      add("lw_a3",     3'd3, 32'h12345678, 12'h003, 32'h12345678);
      add("lwl_a3",    3'd2, 32'h12345678, 12'h003, 32'h12345678);
      add("op6_a3",    3'd6, 32'h12345678, 12'h003, 32'h12345678);
      add("op7_a3",    3'd7, 32'h12345678, 12'h003, 32'h12345678);
      add("lb_hi_000", 3'd0, 32'h807F01FE, 12'h000, 32'hFFFFFFFE);
      add("lb_hi_ffc", 3'd0, 32'h807F01FE, 12'hFFC, 32'hFFFFFFFE);
      add("lbu_hi_ffd",3'd4, 32'h807F01FE, 12'hFFD, 32'h00000001);

      // Reset held for two edges with an all-ones word.
      reset         = 1'b0;
      bus.opcode    = 3'd3;
      bus.entrada   = 32'hFFFFFFFF;
      bus.direccion = 12'h000;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset", bus.salida, 32'h00000000);

      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].opcode, vecs[i].entrada, vecs[i].direccion);
         check(vecs[i].name, bus.salida, vecs[i].expected);
      end

      // Mid-stream reset clears regardless of inputs, then first edge loads.
      @(negedge clk);
      reset = 1'b0;
      apply(3'd3, 32'hDEADBEEF, 12'h000);
      check("midreset", bus.salida, 32'h00000000);
      @(negedge clk);
      reset = 1'b1;
      apply(3'd0, 32'h000000A5, 12'h000);
      check("post_reset", bus.salida, 32'hFFFFFFA5);

      // One-cycle latency: output holds the previous edge's result until the next edge.
      @(negedge clk);
      bus.opcode  = 3'd4;
      bus.entrada = 32'h00000033;
      #1;
      check("latency_hold", bus.salida, 32'hFFFFFFA5);
      @(posedge clk);
      #1;
      check("latency_load", bus.salida, 32'h00000033);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
